// File: rtl/tile_coord_if.sv
// Tile-index input stream plus reconstructed-coordinate output stream.
// The slave modport is the reconstructor side. The master modport is the
// upstream producer combined with the downstream consumer.
interface tile_coord_if #(
    parameter int LANES = 4,
    parameter int IDX_W = 4
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANES*2*IDX_W-1:0] tile_indices;
    logic                     input_valid;
    logic                     input_ready;
    logic [31:0]              coord_out;
    logic [IDX_W-1:0]         tile_x;
    logic [IDX_W-1:0]         tile_y;
    logic [LANE_W-1:0]        lane;
    logic                     last;
    logic                     valid;
    logic                     out_ready;

    modport slave (
        input  tile_indices, input_valid, out_ready,
        output input_ready, coord_out, tile_x, tile_y, lane, last, valid
    );

    modport master (
        output tile_indices, input_valid, out_ready,
        input  input_ready, coord_out, tile_x, tile_y, lane, last, valid
    );
endinterface

// File: rtl/tile_coord_reconstructor.sv
// Serialises one packed word of LANES tile indices ({Y,X} per byte) into
// LANES tile-origin coordinates on a valid/ready stream.
// Optional macro TILE_CENTER_EN: coord_out points at the tile centre
// (bits X_LSB-1 and Y_LSB-1 set) instead of the tile origin.
module tile_coord_reconstructor #(
    parameter int LANES = 4,
    parameter int IDX_W = 4,
    parameter int X_LSB = 6,
    parameter int Y_LSB = 16
) (
    input  logic        clk,
    input  logic        reset,
    tile_coord_if.slave bus
);
    localparam int LW     = 2 * IDX_W;
    localparam int LANE_W = $clog2(LANES);
`ifdef TILE_CENTER_EN
    localparam logic [31:0] CENTER = (32'd1 << (X_LSB - 1)) | (32'd1 << (Y_LSB - 1));
`else
    localparam logic [31:0] CENTER = 32'd0;
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                state_q, state_d;
    logic [LANES*LW-1:0]   word_q;
    logic [31:0]           coord_q;
    logic [IDX_W-1:0]      x_q, y_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  last_q, valid_q;

    logic                  ready_c, in_acc, out_acc;
    logic                  load, adv, drop;
    logic [LANES*LW-1:0]   src_word;
    logic [LANE_W-1:0]     nxt_lane;

    logic [LANES-1:0][IDX_W-1:0] lane_x, lane_y;
    logic [LANES-1:0][31:0]      lane_coord;

    // Ready is free in IDLE, or when the final point is leaving this cycle.
    assign ready_c = (state_q == IDLE) || (valid_q && bus.out_ready && last_q);
    assign in_acc  = bus.input_valid && ready_c;
    assign out_acc = valid_q && bus.out_ready;

    // A new word is decoded straight from the input so lane 0 appears one cycle after accept.
    assign src_word = load ? bus.tile_indices : word_q;
    assign nxt_lane = load ? '0 : lane_q + LANE_W'(1);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_x[g]     = src_word[g*LW +: IDX_W];
        assign lane_y[g]     = src_word[g*LW+IDX_W +: IDX_W];
        assign lane_coord[g] = (32'(lane_y[g]) << Y_LSB) | (32'(lane_x[g]) << X_LSB) | CENTER;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath strobes: load a word, advance a lane, or go empty.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    state_d = EMIT;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (out_acc) begin
                    if (!last_q)     adv  = 1'b1;
                    else if (in_acc) load = 1'b1;
                    else begin
                        state_d = IDLE;
                        drop    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word buffer and output registers; everything holds while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            coord_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (load) word_q <= bus.tile_indices;
            if (load || adv) begin
                coord_q <= lane_coord[nxt_lane];
                x_q     <= lane_x[nxt_lane];
                y_q     <= lane_y[nxt_lane];
                lane_q  <= nxt_lane;
                last_q  <= (nxt_lane == LANE_W'(LANES - 1));
                valid_q <= 1'b1;
            end else if (drop) begin
                last_q  <= 1'b0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.input_ready = ready_c;
    assign bus.coord_out   = coord_q;
    assign bus.tile_x      = x_q;
    assign bus.tile_y      = y_q;
    assign bus.lane        = lane_q;
    assign bus.last        = last_q;
    assign bus.valid       = valid_q;
endmodule

// File: tb/tb_tile_coord_reconstructor.sv
// Directed bench for tile_coord_reconstructor; expected coordinates are hand-computed.
module tb_tile_coord_reconstructor;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    tile_coord_if bus ();

    tile_coord_reconstructor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef TILE_CENTER_EN
    localparam logic [31:0] CEN = 32'h0000_8020;
`else
    localparam logic [31:0] CEN = 32'h0000_0000;
`endif
    localparam logic [31:0] WORD_A = 32'h4321A5F0;
    localparam logic [31:0] WORD_B = 32'hFFFFFFFF;

    logic [31:0] exp_a [4];
    logic [31:0] exp_b;
    logic [3:0]  exp_ax [4];
    logic [3:0]  exp_ay [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_a[0] = 32'h000F0000 | CEN;
        exp_a[1] = 32'h000A0140 | CEN;
        exp_a[2] = 32'h00020040 | CEN;
        exp_a[3] = 32'h000400C0 | CEN;
        exp_b    = 32'h000F03C0 | CEN;
        exp_ax   = '{4'h0, 4'h5, 4'h1, 4'h3};
        exp_ay   = '{4'hF, 4'hA, 4'h2, 4'h4};

        reset = 1'b1;
        bus.tile_indices = '0;
        bus.input_valid  = 1'b0;
        bus.out_ready    = 1'b1;

        // reset then idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_coord", bus.coord_out, 32'd0);
        chk("rst_ready", 32'(bus.input_ready), 32'd1);
        chk("rst_lane",  32'(bus.lane), 32'd0);
        chk("rst_last",  32'(bus.last), 32'd0);

        // single word, free-flowing output
        bus.tile_indices = WORD_A;
        bus.input_valid  = 1'b1;
        @(negedge clk);
        bus.input_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w1_valid%0d", i), 32'(bus.valid), 32'd1);
            chk($sformatf("w1_coord%0d", i), bus.coord_out, exp_a[i]);
            chk($sformatf("w1_lane%0d", i),  32'(bus.lane), 32'(i));
            chk($sformatf("w1_last%0d", i),  32'(bus.last), 32'(i == 3));
            chk($sformatf("w1_x%0d", i),     32'(bus.tile_x), 32'(exp_ax[i]));
            chk($sformatf("w1_y%0d", i),     32'(bus.tile_y), 32'(exp_ay[i]));
            @(negedge clk);
        end
        chk("w1_idle_valid", 32'(bus.valid), 32'd0);
        chk("w1_idle_ready", 32'(bus.input_ready), 32'd1);

        // backpressure on lane 1
        bus.input_valid = 1'b1;
        @(negedge clk);
        bus.input_valid = 1'b0;
        chk("bp_coord0", bus.coord_out, exp_a[0]);
        @(negedge clk);
        chk("bp_coord1", bus.coord_out, exp_a[1]);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_coord%0d", i), bus.coord_out, exp_a[1]);
            chk($sformatf("bp_hold_lane%0d", i),  32'(bus.lane), 32'd1);
            chk($sformatf("bp_hold_valid%0d", i), 32'(bus.valid), 32'd1);
            chk($sformatf("bp_hold_ready%0d", i), 32'(bus.input_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_coord2", bus.coord_out, exp_a[2]);
        @(negedge clk);
        chk("bp_coord3", bus.coord_out, exp_a[3]);
        chk("bp_last3",  32'(bus.last), 32'd1);
        @(negedge clk);
        chk("bp_idle_valid", 32'(bus.valid), 32'd0);

        // back-to-back words, upstream holds word B until accepted
        bus.tile_indices = WORD_A;
        bus.input_valid  = 1'b1;
        @(negedge clk);
        bus.tile_indices = WORD_B;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_valid%0d", i), 32'(bus.valid), 32'd1);
            chk($sformatf("b2b_coord%0d", i), bus.coord_out, (i < 4) ? exp_a[i] : exp_b);
            chk($sformatf("b2b_lane%0d", i),  32'(bus.lane), 32'(i % 4));
            if (i == 3) chk("b2b_ready3", 32'(bus.input_ready), 32'd1);
            if (i == 4) bus.input_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b_idle_valid", 32'(bus.valid), 32'd0);

        // reset while lane 2 is presented
        bus.tile_indices = WORD_A;
        bus.input_valid  = 1'b1;
        @(negedge clk);
        bus.input_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_lane2", 32'(bus.lane), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mr_async_valid", 32'(bus.valid), 32'd0);
        chk("mr_async_coord", bus.coord_out, 32'd0);
        chk("mr_async_ready", 32'(bus.input_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mr_post_valid%0d", i), 32'(bus.valid), 32'd0);
            chk($sformatf("mr_post_ready%0d", i), 32'(bus.input_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
